// File: rtl/seg7_scan_decoder_if.sv
// Output word channel of the seven-segment scan decoder.
// Carries the assembled word, its recovered pre-negation value and valid/ready.
// master: decoder side (drives word + valid); slave: consumer side (drives ready).
interface seg7_scan_decoder_if;
    logic [15:0] num_out;    // assembled word, digit i in num_out[4i+3:4i]
    logic [13:0] orig_out;   // (~num_out[13:0] + 1) mod 2^14, or 0 when negation is disabled
    logic        valid_out;  // word available, held until accepted
    logic        ready_in;   // consumer accepts when valid_out & ready_in

    modport master (
        output num_out,
        output orig_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  num_out,
        input  orig_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Purpose: recovers 4 hex digits from a multiplexed active-low 7-seg bus into a 16-bit word.
// Latency: 2 sync + STABLE_CYCLES cycles to a digit sample; word valid 1 cycle after the digit-3 sample.
// Backpressure: none onto the scan; a word completed while one is pending is dropped and flags ovf_out.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   an_in[3:0]      active-low digit enables (asynchronous)
//   seg_in[6:0]     active-low segments {g,f,e,d,c,b,a} (asynchronous)
//   clr_in          synchronous clear of err_out / ovf_out (a coincident set wins)
//   out_if          master: num_out, orig_out, valid_out out; ready_in in
//   err_out         sticky illegal segment code / multiple anodes flag
//   ovf_out         sticky lost-word flag
// Build option: define SEG7_DEC_NEG_EN to compute orig_out; otherwise it is tied to zero.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4    // legal range 2..255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  an_in,
    input  logic [6:0]                  seg_in,
    input  logic                        clr_in,
    seg7_scan_decoder_if.master         out_if,
    output logic                        err_out,
    output logic                        ovf_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // The counter reaches STABLE_CYCLES-1 in the cycle it currently holds STABLE_CYCLES-2
    // and the bus is unchanged: that is the cycle in which the digit is sampled.
    localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);

    // ------------------------------------------------------------------
    // Input synchronizer and stability counter
    // ------------------------------------------------------------------
    logic [3:0]  an_s1, an_s2;
    logic [6:0]  seg_s1, seg_s2;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q;
    logic        changed;
    logic        fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= 4'hF;
            an_s2  <= 4'hF;
            seg_s1 <= 7'h7F;
            seg_s2 <= 7'h7F;
        end else begin
            an_s1  <= an_in;
            an_s2  <= an_s1;
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
        end
    end

    assign changed = ({an_s2, seg_s2} != prev_q);
    assign fire    = !changed && (cnt_q == CNT_FIRE);

    // Counter saturates so a long dwell cannot wrap around and sample a second time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 11'h7FF;
            cnt_q  <= 8'd0;
        end else begin
            prev_q <= {an_s2, seg_s2};
            if (changed)
                cnt_q <= 8'd0;
            else if (cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Segment and anode decode of the synchronized bus
    // ------------------------------------------------------------------
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [4:0] dec;
    logic [3:0] nib;
    logic       seg_ok;
    logic       an_blank;
    logic       an_one;
    logic [1:0] digit;

    assign dec    = seg_decode(seg_s2);
    assign seg_ok = dec[4];
    assign nib    = dec[3:0];

    always_comb begin
        an_blank = 1'b0;
        an_one   = 1'b0;
        digit    = 2'd0;
        case (an_s2)
            4'b1111: an_blank = 1'b1;
            4'b1110: begin an_one = 1'b1; digit = 2'd0; end
            4'b1101: begin an_one = 1'b1; digit = 2'd1; end
            4'b1011: begin an_one = 1'b1; digit = 2'd2; end
            4'b0111: begin an_one = 1'b1; digit = 2'd3; end
            default: ;  // two or more anodes low
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  expect_q, expect_d;
    logic [15:0] shadow_q, shadow_d;
    logic        complete;
    logic        err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            expect_q <= 2'd0;
            shadow_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        shadow_d = shadow_q;
        complete = 1'b0;
        err_set  = 1'b0;
        if (fire && !an_blank) begin
            if (!an_one || !seg_ok) begin
                err_set = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (digit == 2'd0) begin
                            shadow_d[3:0] = nib;
                            expect_d      = 2'd1;
                            state_d       = COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (digit == expect_q) begin
                            shadow_d[{digit, 2'b00} +: 4] = nib;
                            if (digit == 2'd3) begin
                                complete = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                expect_d = expect_q + 2'd1;
                            end
                        end else if (digit == 2'd0) begin
                            // Out-of-order digit 0 starts a fresh frame rather than wasting a scan.
                            shadow_d[3:0] = nib;
                            expect_d      = 2'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output handoff and sticky flags
    // ------------------------------------------------------------------
    logic [15:0] num_q;
    logic        valid_q;
    logic        err_q;
    logic        ovf_q;
    logic        load;
    logic        ovf_set;

    // A completing frame may replace a word in the very cycle it is accepted.
    assign load    = complete && (!valid_q || out_if.ready_in);
    assign ovf_set = complete && valid_q && !out_if.ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q   <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load) begin
                num_q   <= shadow_d;
                valid_q <= 1'b1;
            end else if (valid_q && out_if.ready_in) begin
                valid_q <= 1'b0;
            end
            if (err_set)
                err_q <= 1'b1;
            else if (clr_in)
                err_q <= 1'b0;
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (clr_in)
                ovf_q <= 1'b0;
        end
    end

`ifdef SEG7_DEC_NEG_EN
    logic [13:0] orig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            orig_q <= 14'd0;
        else if (load)
            orig_q <= ~shadow_d[13:0] + 14'd1;
    end

    assign out_if.orig_out = orig_q;
`else
    assign out_if.orig_out = 14'd0;
`endif

    assign out_if.num_out   = num_q;
    assign out_if.valid_out = valid_q;
    assign err_out          = err_q;
    assign ovf_out          = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: scans digits onto the 7-seg bus,
// pushes the expected word to a scoreboard when a frame is driven and compares on handoff.
// Scenario tasks additionally check flags, latency and reset behaviour inline.
module tb_seg7_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] an_in;
    logic [6:0] seg_in;
    logic       clr_in;
    logic       err_out;
    logic       ovf_out;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .an_in   (an_in),
        .seg_in  (seg_in),
        .clr_in  (clr_in),
        .out_if  (bus),
        .err_out (err_out),
        .ovf_out (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] exp_orig(input logic [15:0] w);
`ifdef SEG7_DEC_NEG_EN
        logic [13:0] lo;
        lo = w[13:0];
        return 14'((~lo) + 14'd1);
`else
        return (w[0] === 1'bx) ? 14'h3FFF : 14'd0;
`endif
    endfunction

    // Scoreboard: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (rst_n && bus.valid_out && bus.ready_in) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got num=%h, none expected", bus.num_out);
            end else begin
                logic [15:0] w;
                w = exp_q.pop_front();
                if (bus.num_out !== w || bus.orig_out !== exp_orig(w)) begin
                    n_err++;
                    $display("FAIL word: got num=%h orig=%h, want num=%h orig=%h",
                             bus.num_out, bus.orig_out, w, exp_orig(w));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show_raw(input int d, input logic [6:0] s, input int cycles);
        logic [3:0] a;
        a      = 4'b0001 << d;
        an_in  = ~a;
        seg_in = s;
        tick(cycles);
    endtask

    task automatic show(input int d, input logic [3:0] n, input int cycles);
        show_raw(d, enc(n), cycles);
    endtask

    task automatic blank(input int cycles);
        an_in  = 4'hF;
        seg_in = 7'h7F;
        tick(cycles);
    endtask

    task automatic frame(input logic [15:0] w);
        show(0, w[3:0], 10);
        show(1, w[7:4], 10);
        show(2, w[11:8], 10);
        show(3, w[15:12], 10);
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        an_in       = 4'hF;
        seg_in      = 7'h7F;
        clr_in      = 1'b0;
        bus.ready_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_vec++;
        if (bus.num_out !== 16'h0 || bus.orig_out !== 14'h0) begin
            n_err++;
            $display("FAIL reset_word: got num=%h orig=%h, want 0", bus.num_out, bus.orig_out);
        end
        n_vec++;
        if (bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b, want 0", bus.valid_out);
        end
        n_vec++;
        if (err_out !== 1'b0 || ovf_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got err=%b ovf=%b, want 0 0", err_out, ovf_out);
        end
        blank(10);
    endtask

    task automatic test_basic;
        bus.ready_in = 1'b0;
        exp_q.push_back(16'h1234);
        show(0, 4'h4, 10);
        show(1, 4'h3, 10);
        show(2, 4'h2, 10);
        an_in  = 4'b0111;
        seg_in = enc(4'h1);
        tick(5);
        n_vec++;
        if (bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: valid=%b one cycle before expected, want 0", bus.valid_out);
        end
        tick(1);
        n_vec++;
        if (bus.valid_out !== 1'b1 || bus.num_out !== 16'h1234) begin
            n_err++;
            $display("FAIL latency_valid: got valid=%b num=%h, want 1 1234", bus.valid_out, bus.num_out);
        end
        n_vec++;
        if (bus.orig_out !== exp_orig(16'h1234)) begin
            n_err++;
            $display("FAIL orig_1234: got %h, want %h", bus.orig_out, exp_orig(16'h1234));
        end
        bus.ready_in = 1'b1;
        tick(1);
        n_vec++;
        if (bus.valid_out !== 1'b0 || bus.num_out !== 16'h1234) begin
            n_err++;
            $display("FAIL accept_drop: got valid=%b num=%h, want 0 1234", bus.valid_out, bus.num_out);
        end
        tick(3);
        blank(10);
    endtask

    task automatic test_glitch;
        bus.ready_in = 1'b1;
        exp_q.push_back(16'h1234);
        show(0, 4'h4, 10);
        show(1, 4'h3, 3);
        show(1, 4'h8, 2);
        show(1, 4'h3, 6);
        show(2, 4'h2, 10);
        show(3, 4'h1, 10);
        n_vec++;
        if (err_out !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_err: got err=%b, want 0", err_out);
        end
        blank(10);
    endtask

    task automatic test_error;
        bus.ready_in = 1'b1;
        show(0, 4'h0, 10);
        show(1, 4'h1, 10);
        show_raw(2, 7'h7F, 10);
        show(3, 4'h3, 10);
        n_vec++;
        if (err_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL bad_segment: got err=%b valid=%b, want 1 0", err_out, bus.valid_out);
        end
        exp_q.push_back(16'hA5F0);
        frame(16'hA5F0);
        n_vec++;
        if (err_out !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got err=%b, want 1", err_out);
        end
        clr_in = 1'b1;
        tick(1);
        clr_in = 1'b0;
        n_vec++;
        if (err_out !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got err=%b, want 0", err_out);
        end
        blank(10);
    endtask

    task automatic test_abort;
        bus.ready_in = 1'b1;
        exp_q.push_back(16'hE987);
        show(0, 4'h7, 10);
        show(2, 4'h9, 10);
        show(0, 4'h7, 10);
        show(1, 4'h8, 10);
        show(2, 4'h9, 10);
        show(3, 4'hE, 10);
        n_vec++;
        if (bus.num_out !== 16'hE987) begin
            n_err++;
            $display("FAIL abort_word: got num=%h, want E987", bus.num_out);
        end
        blank(10);
    endtask

    task automatic test_overflow;
        bus.ready_in = 1'b0;
        exp_q.push_back(16'h1111);
        frame(16'h1111);
        n_vec++;
        if (bus.valid_out !== 1'b1 || ovf_out !== 1'b0) begin
            n_err++;
            $display("FAIL pending: got valid=%b ovf=%b, want 1 0", bus.valid_out, ovf_out);
        end
        frame(16'h2222);
        n_vec++;
        if (ovf_out !== 1'b1 || bus.num_out !== 16'h1111 || bus.valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got ovf=%b num=%h valid=%b, want 1 1111 1",
                     ovf_out, bus.num_out, bus.valid_out);
        end
        bus.ready_in = 1'b1;
        tick(1);
        n_vec++;
        if (bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_accept: got valid=%b, want 0", bus.valid_out);
        end
        clr_in = 1'b1;
        tick(1);
        clr_in = 1'b0;
        n_vec++;
        if (ovf_out !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b, want 0", ovf_out);
        end
        blank(10);
    endtask

    task automatic test_reset_mid;
        bus.ready_in = 1'b1;
        show(0, 4'h5, 10);
        show(1, 4'h6, 10);
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (bus.num_out !== 16'h0 || bus.orig_out !== 14'h0 || bus.valid_out !== 1'b0 ||
            err_out !== 1'b0 || ovf_out !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got num=%h orig=%h valid=%b err=%b ovf=%b, want all 0",
                     bus.num_out, bus.orig_out, bus.valid_out, err_out, ovf_out);
        end
        an_in  = 4'hF;
        seg_in = 7'h7F;
        tick(2);
        rst_n = 1'b1;
        blank(10);
        exp_q.push_back(16'hC0DE);
        frame(16'hC0DE);
        blank(10);
    endtask

    task automatic test_back_to_back;
        bus.ready_in = 1'b1;
        exp_q.push_back(16'h5A3C);
        exp_q.push_back(16'hBEEF);
        frame(16'h5A3C);
        frame(16'hBEEF);
        blank(10);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words never delivered, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_error();
        test_abort();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the team's seven-segment hex display encoder. It samples a multiplexed 4-digit, active-low seven-segment bus (anodes plus segments), debounces each digit dwell, and decodes the segment patterns back into hex nibbles. It then assembles a 16-bit word and hands it out over a valid/ready interface, together with the recovered 14-bit pre-negation value. It is used in board-level self-check and loopback of the display path.

## Interface
Parameters:
- STABLE_CYCLES, 4: synchronized {an_in, seg_in} must be unchanged for this many consecutive cycles before a digit is sampled; legal range 2..255.

Ports:
- clk  in  1  system clock, single clock domain; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- an_in  in  4  active-low digit enables; bit i selects digit i; asynchronous to clk.
- seg_in  in  7  active-low segments {g,f,e,d,c,b,a}; asynchronous to clk.
- ready_in  in  1  consumer accepts the word when ready_in and valid_out are both 1.
- clr_in  in  1  synchronous clear of err_out and ovf_out.
- num_out  out  16  assembled word; digit i sits in num_out[4i+3:4i].
- orig_out  out  14  (~num_out[13:0] + 1) mod 2^14.
- valid_out  out  1  word available; held until accepted.
- err_out  out  1  sticky illegal-pattern or illegal-anode flag.
- ovf_out  out  1  sticky flag: a frame was lost while valid_out was pending.

## Operation
- Synchronizer: 2-flop synchronizer on an_in and seg_in; the synchronizer flops reset to all-ones.
- Stability counter: cleared whenever the synchronized {an, seg} differs from its previous value; otherwise increments and saturates. A sample fires exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1.
- Anode handling at a sample:
  - an = 4'b1111: ignored, with no effect on the frame.
  - Exactly one bit low: digit index d, decoded as below.
  - More than one bit low: error.
- Segment decode, seg to nibble. Any other code is an error.
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
- Frame FSM, states IDLE and COLLECT, with a 2-bit expected index and a 16-bit shadow word:
  - IDLE: a legal sample with d=0 writes shadow[3:0], sets expect=1, and moves to COLLECT. Other samples are discarded.
  - COLLECT: a legal sample with d==expect writes that nibble. When d==3, the frame completes and the FSM goes to IDLE.
  - COLLECT, d≠expect: abort. If d==0, restart the frame with this sample, staying in COLLECT with expect=1. Otherwise go to IDLE.
  - Error at any sample: err_out←1 and the FSM goes to IDLE. The shadow contents are discarded.
- Output handoff:
  - On frame completion with valid_out=0, or with valid_out=1 and ready_in=1 in the same cycle: load num_out and orig_out, and set valid_out←1.
  - On frame completion with valid_out=1 and ready_in=0: ovf_out←1; num_out is unchanged.
  - Acceptance (valid_out & ready_in) with no completion: valid_out←0, and num_out holds its value.
- clr_in clears err_out and ovf_out. If clr_in coincides with a new set condition, the set wins.
- Reset mid-frame: everything returns to its reset value immediately; the partial frame is lost.

## Timing
- Reset values: num_out=0, orig_out=0, valid_out=0, err_out=0, ovf_out=0, FSM=IDLE, counter=0.
- Input change to sample: 2 (sync) + STABLE_CYCLES clk cycles.
- A digit-3 sample in cycle N drives num_out, orig_out and valid_out in cycle N+1. err_out sets in N+1 for an error sampled in N.
- Dwells shorter than STABLE_CYCLES synchronized cycles produce no sample.
- Throughput: one word per 4 dwells. There is no backpressure onto the scan; lost words are reported only via ovf_out.

## Configuration
- SEG7_DEC_NEG_EN defined: orig_out is computed and registered as specified.
- SEG7_DEC_NEG_EN undefined: the negation logic is removed and orig_out is tied to 14'd0. All other behaviour is identical.

## Test plan
- Scan digits 0..3 showing 4,3,2,1 (STABLE_CYCLES=4, dwell 10 cycles each) → num_out=16'h1234, valid_out=1 one cycle after the digit-3 sample, orig_out=14'h2DCC (macro on) or 14'h0000 (macro off).
- Segment glitch of 2 cycles mid-dwell on digit 1 → no extra sample; frame still decodes 16'h1234; err_out=0.
- Digit 2 shows 1111111 → err_out=1, no valid_out; the next clean frame for 0xA5F0 gives num_out=16'hA5F0; clr_in then clears err_out.
- Scan order 0,2,0,1,2,3 with nibbles 7,9,7,8,9,E → first frame aborted; num_out=16'hE987 after the final digit 3.
- ready_in held 0 across two frames (0x1111 then 0x2222) → num_out stays 16'h1111, ovf_out=1; raising ready_in drops valid_out next cycle.
- rst_n pulsed low after digit 1 of a frame → all outputs 0 asynchronously; the following full frame decodes correctly.
